// File: rtl/vidmem_arbiter.sv
// Single-port character RAM arbiter: display reads win, host writes queue in a FIFO, plus a full-screen clear engine.
// Optional stall statistics port starve_cnt is enabled by defining VIDMEM_ARB_STATS_EN.
module vidmem_arbiter #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 8,
  parameter int CELLS   = 2400,
  parameter int FIFO_AW = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              disp_rvalid,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_char,
  output logic              clr_busy,
  output logic [FIFO_AW:0]  fifo_level,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef VIDMEM_ARB_STATS_EN
  ,
  output logic [15:0]       starve_cnt
`endif
);

  localparam int                DEPTH     = 1 << FIFO_AW;
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);
  localparam logic [ADDR_W-1:0] CNT_ONE   = ADDR_W'(1);
  localparam logic [FIFO_AW:0]  LVL_ONE   = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

  typedef enum logic [1:0] {IDLE, CLR_WAIT, CLR_RUN} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  clr_cnt;
  logic [DATA_W-1:0]  clr_char_q;
  logic [ADDR_W-1:0]  fifo_addr [DEPTH];
  logic [DATA_W-1:0]  fifo_data [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   level;
  logic [FIFO_AW:0]   level_nxt;
  logic               fifo_empty;
  logic               fifo_full;
  logic               push;
  logic               pop;
  logic               clr_wr;
  logic               vld_p1;

  // Full is the MSB of the level since the level never exceeds DEPTH.
  assign fifo_empty = (level == '0);
  assign fifo_full  = level[FIFO_AW];
  assign wr_ready   = rst_n & (state == IDLE) & ~fifo_full;
  assign push       = wr_valid & wr_ready;
  assign pop        = ~disp_req & (state != CLR_RUN) & ~fifo_empty;
  assign clr_wr     = ~disp_req & (state == CLR_RUN);
  assign fifo_level = level;

  always_comb begin
    level_nxt = level;
    if (push && !pop)
      level_nxt = level + LVL_ONE;
    else if (pop && !push)
      level_nxt = level - LVL_ONE;
  end

  always_comb begin
    mem_addr  = disp_addr;
    mem_wdata = fifo_data[rd_ptr];
    mem_we    = 1'b0;
    if (disp_req) begin
      mem_addr = disp_addr;
    end else if (clr_wr) begin
      mem_addr  = clr_cnt;
      mem_wdata = clr_char_q;
      mem_we    = rst_n;
    end else if (pop) begin
      mem_addr = fifo_addr[rd_ptr];
      mem_we   = rst_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      level <= level_nxt;
      if (push)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= wr_addr;
      fifo_data[wr_ptr] <= wr_data;
    end
    if (state == IDLE && clr_start)
      clr_char_q <= clr_char;
  end

  // A clear only starts once every queued host write has landed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      clr_cnt  <= '0;
      clr_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_start) begin
            state    <= (level_nxt == '0) ? CLR_RUN : CLR_WAIT;
            clr_cnt  <= '0;
            clr_busy <= 1'b1;
          end
        end
        CLR_WAIT: begin
          if (level_nxt == '0) begin
            state   <= CLR_RUN;
            clr_cnt <= '0;
          end
        end
        CLR_RUN: begin
          if (clr_wr) begin
            if (clr_cnt == LAST_CELL) begin
              state    <= IDLE;
              clr_cnt  <= '0;
              clr_busy <= 1'b0;
            end else begin
              clr_cnt <= clr_cnt + CNT_ONE;
            end
          end
        end
        default: begin
          state    <= IDLE;
          clr_busy <= 1'b0;
        end
      endcase
    end
  end

  // Read stage boundary: RAM data returns one cycle after the address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      vld_p1 <= 1'b0;
    else
      vld_p1 <= disp_req;
  end

  assign disp_rvalid = vld_p1;
  assign disp_rdata  = mem_rdata;

`ifdef VIDMEM_ARB_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      starve_cnt <= '0;
    else if (disp_req && (!fifo_empty || state == CLR_RUN))
      starve_cnt <= sat_inc16(starve_cnt);
  end
`endif

endmodule

// File: doc/vidmem_arbiter.md
Name: vidmem_arbiter

Overview:
- Owns the single port of the character video memory and shares it between the display scan reader and a host writer.
- Display reads always win. Host writes are queued in a small FIFO and drained on cycles when the display does not need the port, typically blanking.
- A built-in clear engine fills every cell with one character.
- Sits between the VGA timing/character-fetch logic and the character RAM.

Parameters:
ADDR_W, 12, cell address width (80x30 = 2400 cells)
DATA_W, 8, character code width
CELLS, 2400, number of cells the clear engine writes (addresses 0..CELLS-1)
FIFO_AW, 2, log2 of write FIFO depth (depth 4)

Ports:
clk  in  1  system clock (pixel clock)
rst_n  in  1  asynchronous active-low reset
disp_req  in  1  display reader needs the memory port this cycle
disp_addr  in  ADDR_W  cell address for the display read
disp_rdata  out  DATA_W  read data, equal to mem_rdata
disp_rvalid  out  1  high the cycle after a display read was issued
wr_valid  in  1  host write request
wr_ready  out  1  FIFO can accept a write
wr_addr  in  ADDR_W  host write cell address
wr_data  in  DATA_W  host write character
clr_start  in  1  one-cycle pulse requesting a full-screen clear
clr_char  in  DATA_W  fill character, sampled on an accepted clr_start
clr_busy  out  1  high while in CLR_WAIT or CLR_RUN
fifo_level  out  FIFO_AW+1  number of queued writes
mem_addr  out  ADDR_W  memory address
mem_we  out  1  memory write enable
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, one-cycle synchronous read latency

Behaviour:
- Asynchronous active-low reset clears all state and outputs:
  - FIFO empty, fifo_level=0.
  - State IDLE, clear counter 0, clr_busy=0.
  - disp_rvalid=0, wr_ready=0 while rst_n=0.
  - mem_we=0 while rst_n=0.
- Port mux is combinational from state and inputs. Exactly one action per cycle, by priority:
  1. disp_req=1: mem_addr=disp_addr, mem_we=0.
  2. State CLR_RUN: mem_addr=clear counter, mem_wdata=latched clr_char, mem_we=1.
  3. State IDLE or CLR_WAIT with FIFO not empty: write the FIFO head and pop it, mem_we=1.
  4. Otherwise mem_we=0 and mem_addr=disp_addr.
- disp_rvalid is a register: it equals disp_req delayed one cycle. disp_rdata is mem_rdata passed through.
- wr_ready = rst_n & (state==IDLE) & (fifo_level < 2^FIFO_AW).
  - A push occurs when wr_valid & wr_ready.
  - A push and a pop in the same cycle leave fifo_level unchanged.
  - When full, wr_ready=0 even if a pop occurs that cycle.
- FIFO order is strict first-in first-out. Read and write pointers wrap modulo the depth.
- State machine:
  - IDLE: an accepted clr_start latches clr_char. Go to CLR_RUN if the FIFO is empty, else CLR_WAIT.
  - CLR_WAIT: drain the FIFO (no new pushes). When the FIFO becomes empty, go to CLR_RUN with counter=0.
  - CLR_RUN: the counter advances only on cycles where the clear write is actually issued (disp_req=0). After writing address CELLS-1, return to IDLE with counter=0.
  - clr_start outside IDLE is ignored.
- A display read never stalls. Writes are delayed for as long as disp_req stays high.
- Reset during CLR_RUN aborts the clear immediately. Cells already written keep their value.

Optional Feature:
- Macro VIDMEM_ARB_STATS_EN.
- Defined: adds output port starve_cnt (16 bits, reset 0).
  - Increments each cycle where a write is pending (FIFO not empty or state CLR_RUN) and disp_req=1.
  - Saturates at 16'hFFFF.
  - Clears on reset only.
- Undefined: the port and its counter are absent. Behaviour is otherwise identical.

Test Plan:
- Reset: hold rst_n=0 mid-stream -> mem_we=0, wr_ready=0, fifo_level=0, disp_rvalid=0. After release: wr_ready=1 next cycle.
- disp_req=0, push (addr 5, data 8'h41) -> next cycle mem_we=1, mem_addr=5, mem_wdata=8'h41, fifo_level back to 0.
- disp_req=1 continuously, push 4 writes -> fifo_level=4, wr_ready=0, no mem_we. Drop disp_req -> 4 writes issued in order on 4 consecutive cycles.
- disp_req pulse at addr 100 with RAM holding 8'h20 -> disp_rvalid=1 one cycle later with disp_rdata=8'h20. A concurrent FIFO write is deferred.
- 2 writes queued, clr_start with clr_char=8'h00 -> the 2 writes land first, then 2400 writes to 0..2399, clr_busy falls after address 2399. With disp_req toggling 50%, the clear completes in about 4800 cycles.
- rst_n pulse at counter=1000 during CLR_RUN -> state IDLE, clr_busy=0, no further clear writes. With VIDMEM_ARB_STATS_EN: 10 blocked cycles -> starve_cnt=10.
